// File: rtl/sprite_addr_gen.sv
`default_nettype none
// ============================================================================
// sprite_addr_gen : raster position -> shared sprite-image ROM address,
//                   fixed-priority over NUM_SPRITES instances, 2-cycle latency.
// Optional macro SPRITE_HFLIP_EN adds per-sprite horizontal mirroring.
// Revision: 1.0
// ============================================================================
module sprite_addr_gen #(
  parameter int WIDTH       = 73,
  parameter int HEIGHT      = 9,
  parameter int SCALE_LOG2  = 2,
  parameter int NUM_SPRITES = 4,
  localparam int ADDR_W     = $clog2(WIDTH * HEIGHT),
  localparam int ID_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                      pixel_clk_in,
  input  logic                      rst_in,
  input  logic [10:0]               hcount_in,
  input  logic [9:0]                vcount_in,
  input  logic                      frame_start_in,
  input  logic [11*NUM_SPRITES-1:0] pos_x_in,
  input  logic [10*NUM_SPRITES-1:0] pos_y_in,
  input  logic [NUM_SPRITES-1:0]    enable_in,
`ifdef SPRITE_HFLIP_EN
  input  logic [NUM_SPRITES-1:0]    hflip_in,
`endif
  output logic [ADDR_W-1:0]         image_addr,
  output logic                      in_sprite,
  output logic [ID_W-1:0]           sprite_id
);

  localparam int SX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SY_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [11:0]     X_LIM  = 12'(WIDTH << SCALE_LOG2);
  localparam logic [11:0]     Y_LIM  = 12'(HEIGHT << SCALE_LOG2);
  localparam logic [SX_W-1:0] SX_MAX = SX_W'(WIDTH - 1);

  // Frame-stable shadow copies of the per-sprite configuration
  logic [11*NUM_SPRITES-1:0] pos_x_q;
  logic [10*NUM_SPRITES-1:0] pos_y_q;
  logic [NUM_SPRITES-1:0]    en_q;
  logic [NUM_SPRITES-1:0]    flip_en;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
      en_q    <= '0;
    end else if (frame_start_in) begin
      pos_x_q <= pos_x_in;
      pos_y_q <= pos_y_in;
      en_q    <= enable_in;
    end
  end

`ifdef SPRITE_HFLIP_EN
  logic [NUM_SPRITES-1:0] flip_q;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      flip_q <= '0;
    end else if (frame_start_in) begin
      flip_q <= hflip_in;
    end
  end

  assign flip_en = flip_q;
`else
  assign flip_en = '0;
`endif

  // Per-sprite offsets; a raster left of / above a sprite wraps to a large value
  logic [11:0]            dx [NUM_SPRITES];
  logic [11:0]            dy [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_sprite
    assign dx[g]  = {1'b0, hcount_in} - {1'b0, pos_x_q[11*g +: 11]};
    assign dy[g]  = {2'b0, vcount_in} - {2'b0, pos_y_q[10*g +: 10]};
    assign hit[g] = en_q[g] && (dx[g] < X_LIM) && (dy[g] < Y_LIM);
  end

  logic            found;
  logic            any_d;
  logic [ID_W-1:0] id_d;
  logic [SX_W-1:0] sx_d;
  logic [SY_W-1:0] sy_d;

  always_comb begin
    found = 1'b0;
    id_d  = '0;
    sx_d  = '0;
    sy_d  = '0;
    any_d = |hit;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (!found && hit[i]) begin
        found = 1'b1;
        id_d  = ID_W'(i);
        sx_d  = SX_W'(dx[i] >> SCALE_LOG2);
        sy_d  = SY_W'(dy[i] >> SCALE_LOG2);
        if (flip_en[i]) begin
          sx_d = SX_MAX - sx_d;
        end
      end
    end
  end

  logic            any_q;
  logic [ID_W-1:0] id1_q;
  logic [SX_W-1:0] sx_q;
  logic [SY_W-1:0] sy_q;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      any_q <= 1'b0;
      id1_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else begin
      any_q <= any_d;
      id1_q <= id_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
    end
  end

  // Stage-1 coordinates are already zero on a miss, so the address follows
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;
  logic              in_q;
  logic [ID_W-1:0]   id2_q;

  assign addr_d = ADDR_W'(32'(sy_q) * 32'(WIDTH) + 32'(sx_q));

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      addr_q <= '0;
      in_q   <= 1'b0;
      id2_q  <= '0;
    end else begin
      addr_q <= addr_d;
      in_q   <= any_q;
      id2_q  <= id1_q;
    end
  end

  assign image_addr = addr_q;
  assign in_sprite  = in_q;
  assign sprite_id  = id2_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_addr_gen.sv
`default_nettype none
// Bench for sprite_addr_gen: scoreboard against an arithmetic reference model.
module tb_sprite_addr_gen;

  localparam int N  = 4;
  localparam int W  = 73;
  localparam int H  = 9;
  localparam int S  = 2;
  localparam int AW = $clog2(W * H);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [10:0]     h   = '0;
  logic [9:0]      v   = '0;
  logic            fs  = 1'b0;
  logic [11*N-1:0] px  = '0;
  logic [10*N-1:0] py  = '0;
  logic [N-1:0]    en  = '0;
  logic [AW-1:0]   image_addr;
  logic            in_sprite;
  logic [1:0]      sprite_id;
`ifdef SPRITE_HFLIP_EN
  logic [N-1:0]    flip = '0;
`endif

  always #5 clk = ~clk;

  sprite_addr_gen #(
    .WIDTH(W), .HEIGHT(H), .SCALE_LOG2(S), .NUM_SPRITES(N)
  ) dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst),
    .hcount_in     (h),
    .vcount_in     (v),
    .frame_start_in(fs),
    .pos_x_in      (px),
    .pos_y_in      (py),
    .enable_in     (en),
`ifdef SPRITE_HFLIP_EN
    .hflip_in      (flip),
`endif
    .image_addr    (image_addr),
    .in_sprite     (in_sprite),
    .sprite_id     (sprite_id)
  );

  typedef struct { bit hit; int addr; int id; } exp_t;
  typedef struct { int tag; bit hit; int addr; int id; int num; } dir_t;

  exp_t q[$];
  dir_t dq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   dnum   = 0;
  int   mx[N];
  int   my[N];
  bit   men[N];
  bit   mfl[N];

  // Reference: first enabled sprite whose scaled box contains the pixel wins
  function automatic exp_t model(int hh, int vv);
    exp_t e;
    e = '{0, 0, 0};
    for (int i = 0; i < N; i++) begin
      int dxm;
      int dym;
      dxm = (hh - mx[i]) & 4095;
      dym = (vv - my[i]) & 4095;
      if (men[i] && dxm < W * (1 << S) && dym < H * (1 << S)) begin
        int sx;
        int sy;
        sx = dxm / (1 << S);
        sy = dym / (1 << S);
        if (mfl[i]) sx = W - 1 - sx;
        e.hit  = 1;
        e.addr = (sy * W + sx) % (1 << AW);
        e.id   = i;
        return e;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t z;
    z = '{0, 0, 0};
    cyc <= cyc + 1;
    if (rst) begin
      if (q.size() > 0) q[q.size()-1] = z;
      q.push_back(z);
      for (int i = 0; i < N; i++) begin
        mx[i] <= 0; my[i] <= 0; men[i] <= 0; mfl[i] <= 0;
      end
    end else begin
      q.push_back(model(int'(h), int'(v)));
      if (fs) begin
        for (int i = 0; i < N; i++) begin
          mx[i]  <= int'(px[11*i +: 11]);
          my[i]  <= int'(py[10*i +: 10]);
          men[i] <= en[i];
`ifdef SPRITE_HFLIP_EN
          mfl[i] <= flip[i];
`endif
        end
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    dir_t d;
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      checks++;
      if (in_sprite !== e.hit || image_addr !== AW'(e.addr) || sprite_id !== 2'(e.id)) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d: got in=%0b addr=%0d id=%0d, expected in=%0b addr=%0d id=%0d",
                 cyc, in_sprite, image_addr, sprite_id, e.hit, e.addr, e.id);
      end
    end
    while (dq.size() > 0 && dq[0].tag <= cyc) begin
      d = dq.pop_front();
      checks++;
      if (in_sprite !== d.hit || image_addr !== AW'(d.addr) || sprite_id !== 2'(d.id)) begin
        errors++;
        $display("FAIL directed#%0d: got in=%0b addr=%0d id=%0d, expected in=%0b addr=%0d id=%0d",
                 d.num, in_sprite, image_addr, sprite_id, d.hit, d.addr, d.id);
      end
    end
  end

  task automatic set_sprite(input int i, input int x, input int y);
    px[11*i +: 11] = 11'(x);
    py[10*i +: 10] = 10'(y);
  endtask

  task automatic frame();
    @(negedge clk);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
  endtask

  task automatic dcheck(input int hh, input int vv, input bit ehit, input int eaddr, input int eid);
    @(negedge clk);
    h = 11'(hh);
    v = 10'(vv);
    dq.push_back('{cyc + 2, ehit, eaddr, eid, dnum});
    dnum++;
    @(posedge clk);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dcheck(0, 0, 0, 0, 0);

    // Single sprite at the origin, 4x scale
    set_sprite(0, 0, 0);
    en = 4'b0001;
    frame();
    dcheck(7, 5, 1, 74, 0);
    dcheck(291, 35, 1, 656, 0);
    dcheck(292, 35, 0, 0, 0);
    dcheck(0, 36, 0, 0, 0);

    // Overlap: lowest index wins
    set_sprite(0, 10, 10);
    set_sprite(2, 10, 10);
    en = 4'b0101;
    frame();
    dcheck(10, 10, 1, 0, 0);
    dcheck(15, 13, 1, 1, 0);
    en = 4'b0100;
    frame();
    dcheck(10, 10, 1, 0, 2);

    // Mid-frame position change is ignored until the next frame start
    set_sprite(2, 400, 300);
    dcheck(14, 10, 1, 1, 2);
    dcheck(400, 300, 0, 0, 0);
    frame();
    dcheck(400, 300, 1, 0, 2);
    dcheck(14, 10, 0, 0, 0);

    // Right edge: no wrap alias, then reset during a hit
    set_sprite(1, 2040, 0);
    en = 4'b0010;
    frame();
    dcheck(5, 0, 0, 0, 0);
    dcheck(2040, 0, 1, 0, 1);
    dcheck(2047, 3, 1, 1, 1);
    dcheck(2040, 0, 1, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    dq.push_back('{cyc + 1, 0, 0, 0, dnum});
    dnum++;
    @(negedge clk);
    rst = 1'b0;
    dcheck(2040, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    dcheck(2040, 0, 0, 0, 0);
    frame();
    dcheck(2040, 0, 1, 0, 1);

`ifdef SPRITE_HFLIP_EN
    set_sprite(0, 0, 0);
    en   = 4'b0001;
    flip = 4'b0001;
    frame();
    dcheck(0, 0, 1, 72, 0);
    dcheck(288, 4, 1, 73, 0);
`endif

    for (int it = 0; it < 3000; it++) begin
      int k;
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) begin
        for (int i = 0; i < N; i++) begin
          set_sprite(i, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
        end
        en = N'($urandom);
`ifdef SPRITE_HFLIP_EN
        flip = N'($urandom);
`endif
      end
      fs  = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) begin
        h = 11'($urandom);
        v = 10'($urandom);
      end else begin
        k = int'($urandom_range(0, N - 1));
        h = 11'(int'(px[11*k +: 11]) + int'($urandom_range(0, 300)) - 4);
        v = 10'(int'(py[10*k +: 10]) + int'($urandom_range(0, 40)) - 2);
      end
    end

    @(negedge clk);
    rst = 1'b0;
    fs  = 1'b0;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
